// File: rtl/sum_acc_pkg.sv
// Shared mode encodings and width helper for the sum_accumulator slice.
// Imported by the top and by the adder sub-module.
package sum_acc_pkg;

  localparam logic [1:0] MODE_ADD_WRAP = 2'b00;
  localparam logic [1:0] MODE_ADD_SAT  = 2'b01;
  localparam logic [1:0] MODE_ACCUM    = 2'b10;
  localparam logic [1:0] MODE_CLEAR    = 2'b11;

  // Bits needed to hold a beat count from 0 up to len inclusive.
  function automatic int clog2_len(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/sum_accumulator_sat_add.sv
// Three-operand unsigned adder with optional saturation to 2^W-1.
// Serves both the plain two-operand ADD path (c_i = 0) and the ACCUM path.
module sat_add #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  input  logic         sat_en_i,
  output logic [W-1:0] y_o,
  output logic         ovf_o,
  output logic         carry_o
);

  localparam logic [W+1:0] MAX_VAL = {2'b00, {W{1'b1}}};

  logic [W+1:0] sum;

  // W+2 bits cover the worst case of three full-scale operands.
  always_comb begin
    sum     = {2'b00, a_i} + {2'b00, b_i} + {2'b00, c_i};
    ovf_o   = (sum > MAX_VAL);
    carry_o = sum[W];
    y_o     = (sat_en_i && ovf_o) ? MAX_VAL[W-1:0] : sum[W-1:0];
  end

endmodule

// File: rtl/sum_accumulator.sv
// Wrap/saturate adder and windowed accumulator behind a single registered
// valid/ready output stage.
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter  int W       = 8,
  parameter  int ACC_LEN = 4,
  localparam int CW      = clog2_len(ACC_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  a_i,
  input  logic [W-1:0]  b_i,
  input  logic [1:0]    mode_i,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  y_o,
  output logic          flag_o,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] acc_cnt_o
);

  localparam logic [CW-1:0] LAST_BEAT = CW'(ACC_LEN - 1);

  logic [W-1:0]  y_q, y_d;
  logic          flag_q, flag_d;
  logic          valid_q, valid_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sticky_q, sticky_d;

  logic          accept;
  logic          sticky_nxt;
  logic [W-1:0]  add_c;
  logic          add_sat_en;
  logic [W-1:0]  add_y;
  logic          add_ovf;
  logic          add_carry;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  assign add_c      = (mode_i == MODE_ACCUM) ? acc_q : '0;
  assign add_sat_en = (mode_i != MODE_ADD_WRAP);
  assign sticky_nxt = sticky_q | add_ovf;

  sat_add #(.W(W)) u_sat_add (
    .a_i      (a_i),
    .b_i      (b_i),
    .c_i      (add_c),
    .sat_en_i (add_sat_en),
    .y_o      (add_y),
    .ovf_o    (add_ovf),
    .carry_o  (add_carry)
  );

  always_comb begin
    y_d      = y_q;
    flag_d   = flag_q;
    valid_d  = valid_q && !out_ready;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;

    if (accept) begin
      case (mode_i)
        MODE_ADD_WRAP: begin
          y_d     = add_y;
          flag_d  = add_carry;
          valid_d = 1'b1;
        end
        MODE_ADD_SAT: begin
          y_d     = add_y;
          flag_d  = add_ovf;
          valid_d = 1'b1;
        end
        MODE_ACCUM: begin
          if (cnt_q == LAST_BEAT) begin
            y_d      = add_y;
            flag_d   = sticky_nxt;
            valid_d  = 1'b1;
            acc_d    = '0;
            cnt_d    = '0;
            sticky_d = 1'b0;
          end else begin
            acc_d    = add_y;
            cnt_d    = cnt_q + CW'(1);
            sticky_d = sticky_nxt;
          end
        end
        default: begin
          acc_d    = '0;
          cnt_d    = '0;
          sticky_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q      <= '0;
      flag_q   <= 1'b0;
      valid_q  <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      y_q      <= y_d;
      flag_q   <= flag_d;
      valid_q  <= valid_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign y_o       = y_q;
  assign flag_o    = flag_q;
  assign out_valid = valid_q;
  assign acc_cnt_o = cnt_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench for sum_accumulator (W=8, ACC_LEN=4): directed table,
// hand-written corner sequences and randomized traffic against a behavioural model.
module tb_sum_accumulator;
  import sum_acc_pkg::*;

  localparam int W       = 8;
  localparam int ACC_LEN = 4;
  localparam int CW      = 3;
  localparam int MAXV    = 255;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  a_i, b_i;
  logic [1:0]    mode_i;
  logic          in_valid, in_ready;
  logic [W-1:0]  y_o;
  logic          flag_o, out_valid, out_ready;
  logic [CW-1:0] acc_cnt_o;

  sum_accumulator #(.W(W), .ACC_LEN(ACC_LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_i       (a_i),
    .b_i       (b_i),
    .mode_i    (mode_i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y_o       (y_o),
    .flag_o    (flag_o),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_cnt_o (acc_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state: window sum, beats taken, sticky saturation, output slot.
  int m_acc, m_cnt, m_y;
  bit m_st, m_v, m_f;

  typedef struct {
    logic [1:0] mode;
    int         a;
    int         b;
    int         y;
    bit         f;
    bit         emit;
    int         cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task model_reset();
    m_acc = 0; m_cnt = 0; m_y = 0; m_st = 0; m_v = 0; m_f = 0;
  endtask

  task model_clock();
    int  s;
    bit  rdy, sat;
    rdy = !m_v || out_ready;
    if (out_ready) m_v = 0;
    if (in_valid && rdy) begin
      case (mode_i)
        MODE_ADD_WRAP: begin
          s = int'(a_i) + int'(b_i);
          m_y = s % 256; m_f = (s > MAXV); m_v = 1;
        end
        MODE_ADD_SAT: begin
          s = int'(a_i) + int'(b_i);
          m_y = (s > MAXV) ? MAXV : s; m_f = (s > MAXV); m_v = 1;
        end
        MODE_ACCUM: begin
          s = m_acc + int'(a_i) + int'(b_i);
          sat = (s > MAXV);
          if (sat) s = MAXV;
          if (m_cnt == ACC_LEN - 1) begin
            m_y = s; m_f = m_st | sat; m_v = 1;
            m_acc = 0; m_cnt = 0; m_st = 0;
          end else begin
            m_acc = s; m_cnt = m_cnt + 1; m_st = m_st | sat;
          end
        end
        default: begin
          m_acc = 0; m_cnt = 0; m_st = 0;
        end
      endcase
    end
  endtask

  task check_outputs();
    chk("out_valid", out_valid, m_v);
    chk("y_o", y_o, m_y);
    chk("flag_o", flag_o, m_f);
    chk("acc_cnt_o", acc_cnt_o, m_cnt);
  endtask

  // Called at posedge+1; drives one beat, checks in_ready mid-cycle, then outputs after the edge.
  task automatic cycle(input logic v, input logic [1:0] m, input int aa, input int bb,
                       input logic ordy);
    in_valid  = v;
    mode_i    = m;
    a_i       = W'(aa);
    b_i       = W'(bb);
    out_ready = ordy;
    #4;
    chk("in_ready", in_ready, (!m_v || ordy));
    @(posedge clk);
    model_clock();
    #1;
    check_outputs();
  endtask

  task automatic add_vec(input logic [1:0] m, input int a, input int b, input int y,
                         input bit f, input bit emit, input int cnt);
    vec_t v;
    v.mode = m; v.a = a; v.b = b; v.y = y; v.f = f; v.emit = emit; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; mode_i = 0; a_i = 0; b_i = 0; out_ready = 1;
    model_reset();
    #12;
    check_outputs();
    chk("reset_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    add_vec(MODE_ADD_WRAP, 200, 100, 44, 1, 1, 0);
    add_vec(MODE_ADD_WRAP, 3, 4, 7, 0, 1, 0);
    add_vec(MODE_ADD_SAT, 200, 100, 255, 1, 1, 0);
    add_vec(MODE_ADD_SAT, 100, 27, 127, 0, 1, 0);
    add_vec(MODE_ACCUM, 10, 5, 0, 0, 0, 1);
    add_vec(MODE_ACCUM, 1, 1, 0, 0, 0, 2);
    add_vec(MODE_ACCUM, 2, 2, 0, 0, 0, 3);
    add_vec(MODE_ACCUM, 3, 3, 27, 0, 1, 0);
    add_vec(MODE_ACCUM, 200, 50, 0, 0, 0, 1);
    add_vec(MODE_ACCUM, 10, 0, 0, 0, 0, 2);
    add_vec(MODE_ADD_WRAP, 1, 1, 2, 0, 1, 2);
    add_vec(MODE_CLEAR, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add_vec(MODE_ACCUM, 1, 0, 0, 0, 0, i + 1);
    add_vec(MODE_ACCUM, 1, 0, 4, 0, 1, 0);
    for (int i = 0; i < 3; i++) add_vec(MODE_ACCUM, 200, 0, 0, 0, 0, i + 1);
    add_vec(MODE_ACCUM, 200, 0, 255, 1, 1, 0);

    foreach (tbl[i]) begin
      cycle(1, tbl[i].mode, tbl[i].a, tbl[i].b, 1);
      chk("tbl_valid", out_valid, tbl[i].emit);
      chk("tbl_cnt", acc_cnt_o, tbl[i].cnt);
      if (tbl[i].emit) begin
        chk("tbl_y", y_o, tbl[i].y);
        chk("tbl_flag", flag_o, tbl[i].f);
      end
    end

    // Backpressure: result held while stalled, then drain plus new result back to back.
    cycle(1, MODE_ADD_WRAP, 3, 4, 1);
    for (int i = 0; i < 5; i++) begin
      cycle(1, MODE_ADD_WRAP, 9, 9, 0);
      chk("bp_y_hold", y_o, 7);
      chk("bp_in_ready", in_ready, 0);
    end
    cycle(1, MODE_ADD_WRAP, 9, 9, 1);
    chk("bp_valid_kept", out_valid, 1);
    chk("bp_next_y", y_o, 18);

    // Reset mid-window with a stalled result pending.
    cycle(1, MODE_ACCUM, 5, 5, 1);
    cycle(1, MODE_ACCUM, 5, 5, 1);
    cycle(1, MODE_ADD_WRAP, 1, 2, 0);
    cycle(0, MODE_ADD_WRAP, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_valid", out_valid, 0);
    chk("rst_y", y_o, 0);
    chk("rst_cnt", acc_cnt_o, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    cycle(1, MODE_ACCUM, 7, 7, 1);
    chk("post_rst_cnt", acc_cnt_o, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [1:0] m;
      int aa, bb;
      r = $urandom_range(0, 9);
      m = (r < 2) ? MODE_ADD_WRAP : (r < 4) ? MODE_ADD_SAT : (r < 9) ? MODE_ACCUM : MODE_CLEAR;
      aa = ($urandom_range(0, 7) == 0) ? MAXV : $urandom_range(0, MAXV);
      bb = ($urandom_range(0, 7) == 0) ? MAXV : $urandom_range(0, MAXV);
      cycle($urandom_range(0, 3) != 0, m, aa, bb, $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
